// File: rtl/approx_err_monitor_pkg.sv
// rtl/approx_err_monitor_pkg.sv - shared state type and width helpers for the approximate-adder error monitor
package approx_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Cycles spent in DRAIN so the last sample has left both pipeline stages.
  localparam int DRAIN_CYCLES = 2;

  // Worst-case ED^2 summed over 2^log2_samples samples fits in this many bits.
  function automatic int sse_w(input int width, input int log2_samples);
    return 2 * (width + 1) + log2_samples;
  endfunction

  // The error distance spans the full approximate-sum range.
  function automatic int ed_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// rtl/approx_err_monitor_if.sv - sample stream and result handshake bundle for the error monitor
interface approx_err_monitor_if
  import approx_mon_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int LOG2_SAMPLES = 8
);

  logic                                   in_valid;
  logic                                   in_ready;
  logic [WIDTH-1:0]                       in_a;
  logic [WIDTH-1:0]                       in_b;
  logic [ed_w(WIDTH)-1:0]                 in_approx;
  logic                                   res_valid;
  logic                                   res_ready;
  logic [sse_w(WIDTH, LOG2_SAMPLES)-1:0]  sse;
  logic [ed_w(WIDTH)-1:0]                 max_ed;
  logic [LOG2_SAMPLES:0]                  err_cnt;

  // Producer of samples / consumer of results.
  modport master (
    output in_valid, in_a, in_b, in_approx, res_ready,
    input  in_ready, res_valid, sse, max_ed, err_cnt
  );

  // The monitor itself.
  modport slave (
    input  in_valid, in_a, in_b, in_approx, res_ready,
    output in_ready, res_valid, sse, max_ed, err_cnt
  );

endinterface

// File: rtl/approx_err_monitor_ed_stage.sv
// rtl/approx_err_monitor_ed_stage.sv - stage 1: exact sum and absolute error distance
module approx_ed_stage
  import approx_mon_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [ed_w(WIDTH)-1:0] in_approx,
  output logic [ed_w(WIDTH)-1:0] ed,
  output logic                   ed_valid
);

  localparam int EDW = ed_w(WIDTH);

  logic [EDW-1:0] exact;

  // Carry out of the exact add lands in the extra bit, matching the approximate sum width.
  assign exact = {1'b0, in_a} + {1'b0, in_b};

  // Register |exact - approx| together with its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed       <= '0;
      ed_valid <= 1'b0;
    end else begin
      ed_valid <= in_valid;
      if (in_valid) begin
        ed <= (exact >= in_approx) ? (exact - in_approx) : (in_approx - exact);
      end
    end
  end

endmodule

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - windowed SSE / max ED / error-count monitor for approximate adders
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int LOG2_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  approx_err_monitor_if.slave  mon
);

  localparam int EDW  = ed_w(WIDTH);
  localparam int SSEW = sse_w(WIDTH, LOG2_SAMPLES);
  localparam int CW   = LOG2_SAMPLES + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((64'd1 << LOG2_SAMPLES) - 64'd1);

  state_t         state;
  logic [CW-1:0]  acc_cnt;
  logic [1:0]     drain_cnt;
  logic           accept;
  logic [EDW-1:0] ed;
  logic           ed_valid;
  logic [2*EDW-1:0] ed_sq;

  assign accept = mon.in_valid & mon.in_ready;
  assign ed_sq  = {{EDW{1'b0}}, ed} * {{EDW{1'b0}}, ed};

  approx_ed_stage #(
    .WIDTH (WIDTH)
  ) u_ed_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_a      (mon.in_a),
    .in_b      (mon.in_b),
    .in_approx (mon.in_approx),
    .ed        (ed),
    .ed_valid  (ed_valid)
  );

  // Window control: accept N samples, let the pipeline empty, then hold results until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc_cnt       <= '0;
      drain_cnt     <= '0;
      mon.in_ready  <= 1'b0;
      mon.res_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= ACCUM;
            acc_cnt      <= '0;
            mon.in_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CW'(1);
            if (acc_cnt == LAST_IDX) begin
              state        <= DRAIN;
              drain_cnt    <= '0;
              mon.in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(DRAIN_CYCLES)) begin
            state         <= DONE;
            mon.res_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          if (mon.res_ready) begin
            state         <= IDLE;
            mon.res_valid <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          mon.in_ready  <= 1'b0;
          mon.res_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: fold each stage-1 error distance into the window metrics; cleared only by a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon.sse     <= '0;
      mon.max_ed  <= '0;
      mon.err_cnt <= '0;
    end else if (state == IDLE && start) begin
      mon.sse     <= '0;
      mon.max_ed  <= '0;
      mon.err_cnt <= '0;
    end else if (ed_valid) begin
      mon.sse <= mon.sse + {{(SSEW-2*EDW){1'b0}}, ed_sq};
      if (ed > mon.max_ed) begin
        mon.max_ed <= ed;
      end
      if (ed != '0) begin
        mon.err_cnt <= mon.err_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - self-checking bench for approx_err_monitor
module tb_approx_err_monitor;

  localparam int WIDTH = 16;
  localparam int L2    = 2;
  localparam int N     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  approx_err_monitor_if #(.WIDTH(WIDTH), .LOG2_SAMPLES(L2)) bus ();

  approx_err_monitor #(.WIDTH(WIDTH), .LOG2_SAMPLES(L2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .mon   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: window phase plus metrics computed from the accepted samples.
  int     phase = 0;
  int     acc   = 0;
  int     wcnt  = 0;
  longint m_sse = 0;
  longint m_max = 0;
  longint m_err = 0;
  longint ex, ap, ed;
  logic   e_ir = 1'b0, e_rv = 1'b0, e_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0; acc = 0; wcnt = 0;
      m_sse = 0; m_max = 0; m_err = 0;
      e_ir = 1'b0; e_rv = 1'b0; e_busy = 1'b0;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sse", bus.sse, 0);
    end else begin
      check("in_ready", bus.in_ready, e_ir);
      check("res_valid", bus.res_valid, e_rv);
      check("busy", busy, e_busy);
      if (phase == 0 || phase == 3) begin
        check("model_sse", bus.sse, m_sse);
        check("model_max_ed", bus.max_ed, m_max);
        check("model_err_cnt", bus.err_cnt, m_err);
      end
      case (phase)
        0: if (start) begin
          phase = 1; acc = 0; m_sse = 0; m_max = 0; m_err = 0;
          e_ir = 1'b1; e_busy = 1'b1;
        end
        1: if (bus.in_valid && e_ir) begin
          ex = longint'(bus.in_a) + longint'(bus.in_b);
          ap = longint'(bus.in_approx);
          ed = (ex >= ap) ? ex - ap : ap - ex;
          m_sse += ed * ed;
          if (ed > m_max) m_max = ed;
          if (ed != 0) m_err++;
          acc++;
          if (acc == N) begin
            phase = 2; wcnt = 0; e_ir = 1'b0;
          end
        end
        2: begin
          wcnt++;
          if (wcnt == 3) begin
            phase = 3; e_rv = 1'b1;
          end
        end
        default: if (bus.res_ready) begin
          phase = 0; e_rv = 1'b0; e_busy = 1'b0;
        end
      endcase
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] apx, input logic v);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_approx = apx;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.res_valid && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_within_budget", bus.res_valid, 1);
  endtask

  task automatic expect_res(input string tag, input longint s, input longint m, input longint e);
    check({tag, "_sse"}, bus.sse, s);
    check({tag, "_max_ed"}, bus.max_ed, m);
    check({tag, "_err_cnt"}, bus.err_cnt, e);
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("after_take_busy", busy, 0);
    check("after_take_res_valid", bus.res_valid, 0);
  endtask

  logic [15:0] hs_a [9];
  logic [16:0] hs_ap[9];
  logic        hs_v [9];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_approx = '0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_res("reset", 0, 0, 0);
    check("reset_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact samples, plus explicit result latency after the last accept.
    do_start();
    check("start_in_ready", bus.in_ready, 1);
    send(16'h1234, 16'h4321, 17'h05555, 1'b1);
    send(16'hFFFF, 16'h0001, 17'h10000, 1'b1);
    send(16'h0000, 16'h0000, 17'h00000, 1'b1);
    send(16'h8000, 16'h8000, 17'h10000, 1'b1);
    check("lat_e1_res_valid", bus.res_valid, 0);
    check("lat_e1_in_ready", bus.in_ready, 0);
    @(posedge clk); #1; check("lat_e2_res_valid", bus.res_valid, 0);
    @(posedge clk); #1; check("lat_e3_res_valid", bus.res_valid, 0);
    @(posedge clk); #1; check("lat_e4_res_valid", bus.res_valid, 1);
    expect_res("exact", 0, 0, 0);
    take_res();

    // Mixed errors: EDs 1,2,3,4.
    do_start();
    send(16'd10, 16'd20, 17'd29, 1'b1);
    send(16'd10, 16'd20, 17'd28, 1'b1);
    send(16'd10, 16'd20, 17'd33, 1'b1);
    send(16'd10, 16'd20, 17'd34, 1'b1);
    wait_done();
    expect_res("mixed", 30, 4, 4);
    take_res();

    // Low-bit approximation on one sample.
    do_start();
    send(16'h0001, 16'h0001, 17'h00001, 1'b1);
    send(16'd5, 16'd6, 17'd11, 1'b1);
    send(16'h0100, 16'h0200, 17'h00300, 1'b1);
    send(16'd7, 16'd0, 17'd7, 1'b1);
    wait_done();
    expect_res("real_adder", 1, 1, 1);
    take_res();

    // Worst case: no overflow; start during DONE is ignored.
    do_start();
    for (int i = 0; i < N; i++) send(16'hFFFF, 16'hFFFF, 17'h00000, 1'b1);
    wait_done();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_ignored_in_done", bus.res_valid, 1);
    expect_res("worst", 64'd68717379600, 64'h1FFFE, 4);
    take_res();

    // Handshake: valid gaps, extra offers after N, result held with res_ready low.
    hs_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    hs_ap = '{17'd195, 17'd0, 17'd0, 17'd200, 17'd207, 17'd0, 17'd201, 17'd0, 17'd0};
    do_start();
    for (int i = 0; i < 9; i++) send(16'd100, 16'd100, hs_ap[i], hs_v[i]);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      start = (i < 2);
      expect_res("held", 75, 7, 3);
      check("held_res_valid", bus.res_valid, 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    take_res();
    check("idle_in_ready", bus.in_ready, 0);
    expect_res("idle_keep", 75, 7, 3);

    // Reset mid-window, then a fresh exact window.
    do_start();
    send(16'h0001, 16'h0001, 17'h1FFFF, 1'b1);
    send(16'h00FF, 16'h0000, 17'h00000, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    expect_res("mid_reset", 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    for (int i = 0; i < N; i++) send(16'(i * 3), 16'(i + 1), 17'(i * 4 + 1), 1'b1);
    wait_done();
    expect_res("after_reset", 0, 0, 0);
    take_res();

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Streaming error-metric accumulator that sits directly downstream of the 16-bit approximate ripple-carry adders (area/MSE family). For each accepted sample it takes the adder operands and the approximate 17-bit sum, recomputes the exact sum, and forms the error distance ED = |exact − approx|. Over a window of 2^LOG2_SAMPLES samples it accumulates the sum of squared errors (SSE), the maximum ED and the count of erroneous samples, then presents the results through a valid/ready handshake. It gives the hardware-measured MSE figure for each adder variant.

## Interface
- WIDTH, 16, operand width; the approximate sum is WIDTH+1 bits.
- LOG2_SAMPLES, 8, log2 of window length N = 2^LOG2_SAMPLES (1..16).
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a new window; sampled only in IDLE.
- in_valid  input  1  sample valid.
- in_ready  output  1  monitor can accept a sample.
- in_a  input  WIDTH  adder operand IN1.
- in_b  input  WIDTH  adder operand IN2.
- in_approx  input  WIDTH+1  approximate adder output Out.
- res_valid  output  1  results valid.
- res_ready  input  1  consumer takes results.
- sse  output  2*(WIDTH+1)+LOG2_SAMPLES  sum of ED^2 over the window.
- max_ed  output  WIDTH+1  largest ED in the window.
- err_cnt  output  LOG2_SAMPLES+1  number of samples with ED ≠ 0.
- busy  output  1  state is not IDLE.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE: in_ready=0, res_valid=0. start=1 → clear sse, max_ed, err_cnt, sample counter; go to ACCUM.
- ACCUM: in_ready=1 while accepted count < N. Accept on in_valid&in_ready. The Nth accept → DRAIN; in_ready drops in the following cycle.
- DRAIN: in_ready=0; wait until the pipeline is empty (2 cycles), then go to DONE.
- DONE: res_valid=1, outputs held stable; res_valid&res_ready → IDLE. start is ignored outside IDLE.
- Stage 1 (registered): exact = in_a + in_b, zero-extended to WIDTH+1 bits. ED = exact − in_approx if exact ≥ in_approx, else in_approx − exact. Carry a stage-valid bit.
- Stage 2 (registered, when stage-valid): sse += ED*ED (full 2*(WIDTH+1)-bit product, no truncation); max_ed = max(max_ed, ED); err_cnt += (ED≠0).
- Width choice guarantees no overflow: worst case ED = 2^(WIDTH+1)−2 for all N samples.
- in_valid while in_ready=0 has no effect. Data is not required to be held beyond the accepting cycle.
- Reset mid-operation: all state and pipeline cleared, IDLE, in-flight samples discarded.

## Timing
- Reset values: in_ready=0, res_valid=0, busy=0, sse=0, max_ed=0, err_cnt=0.
- start high in IDLE at edge t → in_ready=1 in the cycle after t.
- Throughput: one sample per cycle with no bubbles.
- Latency: a sample accepted at edge E is reflected in sse/max_ed/err_cnt after edge E+2.
- Last accept at edge E → res_valid=1 from edge E+3, held until the handshake.
- res_valid&res_ready at edge R → res_valid=0 and busy=0 after R. A start seen in the cycle after R opens a new window.
- Outputs in IDLE keep the last window's values until the next start.

## Structure
- Package approx_mon_pkg holds: the state enum (IDLE/ACCUM/DRAIN/DONE) and width functions sse_w(WIDTH, LOG2_SAMPLES) and ed_w(WIDTH).
- Sub-module approx_ed_stage: stage 1 (exact sum, absolute difference, valid bit). The FSM, counter and stage 2 accumulation live in the top.

## Test plan
All scenarios use LOG2_SAMPLES=2 (N=4) unless noted.
- Exact samples: 4 samples with in_approx = in_a+in_b → sse=0, max_ed=0, err_cnt=0; res_valid 3 cycles after the last accept.
- Mixed errors: EDs 1,2,3,4 (approx below exact for the first two, above for the last two) → sse=30, max_ed=4, err_cnt=4.
- Real adder pattern: in_a=in_b=0x0001, in_approx=0x00001 (lower-8-bit approx cells), other 3 samples exact → sse=1, max_ed=1, err_cnt=1.
- Worst case: in_a=in_b=0xFFFF, in_approx=0 ×4 → max_ed=0x1FFFE, sse=68717379600, err_cnt=4; no overflow.
- Handshake: in_valid gaps (1-0-0-1-1-0-1) and res_ready low for 5 cycles → only 4 samples counted, results stable while held, IDLE one cycle after res_ready.
- Reset mid-window: rst_n low after 2 accepts, then new start with 4 exact samples → all outputs 0 and no carry-over from the aborted window.
